// File: rtl/sr_cmd_conditioner.sv
// sr_cmd_conditioner: synchronise, debounce and edge-detect two raw request lines, then issue
// mutually exclusive one-cycle s/r commands with a lockout gap. SR_CMD_LEVEL_MODE_EN selects level-following commands.

module sr_line_cond #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic lvl,
  output logic rise
);
  logic             sync1, sync2, db;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      db    <= 1'b0;
      cnt   <= '0;
      lvl   <= 1'b0;
    end else begin
      sync1 <= req;
      sync2 <= sync1;
      lvl   <= db;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // lvl is the debounced level delayed one cycle, so this is a one-cycle rising-edge strobe
  assign rise = db & ~lvl;
endmodule

module sr_cmd_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 2,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);
  localparam int NUM_LINES = 2;
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  logic [NUM_LINES-1:0] req, lvl, rise, cmd, cmd_clr;
  state_t               state, state_n;
  logic [CNT_W-1:0]     gcnt, gcnt_n;
  logic                 s_n, r_n, conflict_n, ready, hold_s, hold_r;

  // line 0 = set, line 1 = clear
  assign req = {clr_req, set_req};

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    sr_line_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_line (
      .clk (clk),
      .rst (rst),
      .req (req[i]),
      .lvl (lvl[i]),
      .rise(rise[i])
    );
  end

`ifdef SR_CMD_LEVEL_MODE_EN
  assign cmd    = lvl;
  assign hold_s = s & (cmd == 2'b01);
  assign hold_r = r & (cmd == 2'b10);
`else
  logic [NUM_LINES-1:0] pend;

  // a fresh edge wins over a same-cycle clear so it is never lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~cmd_clr) | rise;
  end

  assign cmd    = pend;
  assign hold_s = 1'b0;
  assign hold_r = 1'b0;
`endif

  // the last gap cycle doubles as an idle decision slot, giving 1+GAP_CYCLES command spacing
  assign ready = (state == IDLE) || ((state == GAP) && (gcnt == GAP_LAST));

  always_comb begin
    state_n    = state;
    gcnt_n     = gcnt;
    s_n        = 1'b0;
    r_n        = 1'b0;
    conflict_n = 1'b0;
    cmd_clr    = '0;
    case (state)
      PULSE: begin
        if (hold_s)               s_n = 1'b1;
        else if (hold_r)          r_n = 1'b1;
        else if (GAP_CYCLES == 0) state_n = IDLE;
        else begin
          state_n = GAP;
          gcnt_n  = '0;
        end
      end
      GAP: begin
        gcnt_n = gcnt + 1'b1;
        if (gcnt == GAP_LAST) state_n = IDLE;
      end
      default: ;
    endcase
    if (ready) begin
      if (&cmd) begin
        conflict_n = 1'b1;
        cmd_clr    = 2'b11;
      end else if (cmd[0]) begin
        s_n     = 1'b1;
        cmd_clr = 2'b01;
        state_n = PULSE;
      end else if (cmd[1]) begin
        r_n     = 1'b1;
        cmd_clr = 2'b10;
        state_n = PULSE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gcnt     <= '0;
      s        <= 1'b0;
      r        <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state    <= state_n;
      gcnt     <= gcnt_n;
      s        <= s_n;
      r        <= r_n;
      busy     <= (state_n != IDLE);
      conflict <= conflict_n;
    end
  end
endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Scoreboard bench for sr_cmd_conditioner (DEBOUNCE_CYCLES=4, GAP_CYCLES=2): stimulus queues
// expected output events by cycle, a negedge monitor pops and checks every event the DUT shows.

module tb_sr_cmd_conditioner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  logic s, r, busy, conflict;

  sr_cmd_conditioner #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .set_req (set_req),
    .clr_req (clr_req),
    .s       (s),
    .r       (r),
    .busy    (busy),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_S, EV_R, EV_C, EV_BR, EV_BF} ev_t;
  typedef struct {ev_t k; int c;} ev_s;

  ev_s  exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic busy_q = 1'b0;
  int   e0;

  always @(posedge clk) cyc++;

  task automatic push(input ev_t k, input int c);
    exp_q.push_back('{k, c});
  endtask

  task automatic chk_ev(input ev_t k);
    ev_s e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got %s at cycle %0d, want none", k.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.k != k || e.c != cyc) begin
        bad++;
        $display("FAIL event_order: got %s at cycle %0d, want %s at cycle %0d",
                 k.name(), cyc, e.k.name(), e.c);
      end
    end
  endtask

  task automatic cmp(input string nm, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  // monitor: samples away from the active edge, in fixed S,R,C,BR,BF order per cycle
  always @(negedge clk) begin
    total++;
    if (s & r) begin
      bad++;
      $display("FAIL s_r_exclusive: got s&r=1 at cycle %0d want 0", cyc);
    end
    if (s)              chk_ev(EV_S);
    if (r)              chk_ev(EV_R);
    if (conflict)       chk_ev(EV_C);
    if (busy & ~busy_q) chk_ev(EV_BR);
    if (~busy & busy_q) chk_ev(EV_BF);
    busy_q = busy;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    step(3);
    cmp("reset_s", s, 1'b0);
    cmp("reset_r", r, 1'b0);
    cmp("reset_busy", busy, 1'b0);
    cmp("reset_conflict", conflict, 1'b0);
    rst = 1'b0;
    step(5);

`ifdef SR_CMD_LEVEL_MODE_EN
    // level mode: s follows the held level, then a 2-cycle lockout
    e0 = cyc + 1;
    set_req = 1'b1;
    push(EV_S, e0 + 7);
    push(EV_BR, e0 + 7);
    for (int k = 8; k <= 16; k++) push(EV_S, e0 + k);
    push(EV_BF, e0 + 19);
    step(10);
    set_req = 1'b0;
    step(20);
    cmp("lvl_r_low", r, 1'b0);
`else
    // 1: single set, s after edge 7, busy edges 7..9
    e0 = cyc + 1;
    set_req = 1'b1;
    push(EV_S, e0 + 7);
    push(EV_BR, e0 + 7);
    push(EV_BF, e0 + 10);
    step(12);
    cmp("t1_busy_idle", busy, 1'b0);
    set_req = 1'b0;
    step(14);

    // 2: 3-cycle glitch never passes the debouncer
    set_req = 1'b1;
    step(3);
    set_req = 1'b0;
    step(20);
    cmp("t2_busy", busy, 1'b0);

    // 3: simultaneous set/clear -> one-cycle conflict only
    e0 = cyc + 1;
    set_req = 1'b1;
    clr_req = 1'b1;
    push(EV_C, e0 + 7);
    step(12);
    set_req = 1'b0;
    clr_req = 1'b0;
    step(15);

    // 4: clear 2 cycles after set -> r served at the end of the gap
    e0 = cyc + 1;
    set_req = 1'b1;
    push(EV_S, e0 + 7);
    push(EV_BR, e0 + 7);
    push(EV_R, e0 + 10);
    push(EV_BF, e0 + 13);
    step(2);
    clr_req = 1'b1;
    step(14);
    set_req = 1'b0;
    clr_req = 1'b0;
    step(15);

    // 5: clear 4 cycles after set -> pend lands just after the gap, r one cycle later
    e0 = cyc + 1;
    set_req = 1'b1;
    push(EV_S, e0 + 7);
    push(EV_BR, e0 + 7);
    push(EV_BF, e0 + 10);
    push(EV_R, e0 + 11);
    push(EV_BR, e0 + 11);
    push(EV_BF, e0 + 14);
    step(4);
    clr_req = 1'b1;
    step(14);
    set_req = 1'b0;
    clr_req = 1'b0;
    step(15);

    // 6: reset mid-pulse drops s at once; held request re-fires after release
    e0 = cyc + 1;
    set_req = 1'b1;
    push(EV_S, e0 + 7);
    push(EV_BR, e0 + 7);
    step(8);
    cmp("t6_s_before_rst", s, 1'b1);
    rst = 1'b1;
    #1;
    cmp("t6_s_in_rst", s, 1'b0);
    cmp("t6_busy_in_rst", busy, 1'b0);
    push(EV_BF, cyc + 1);
    step(3);
    rst = 1'b0;
    e0 = cyc + 1;
    push(EV_S, e0 + 7);
    push(EV_BR, e0 + 7);
    push(EV_BF, e0 + 10);
    step(12);
    set_req = 1'b0;
    step(15);
`endif

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_events: got %0d left in queue want 0 (next %s at cycle %0d)",
               exp_q.size(), exp_q[0].k.name(), exp_q[0].c);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
